multdiv_unit: RTL and testbench



---
 rtl/multdiv_pkg.sv | 18 +
 rtl/multdiv_step.sv | 39 +++
 rtl/multdiv_unit.sv | 168 ++++++++++++++++
 tb/tb_multdiv_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multi-cycle signed multiply/divide unit.
// Optional feature macro used by the top: MULTDIV_RSTATUS_WB_EN.
package multdiv_pkg;

  localparam int DEFAULT_WIDTH      = 32;
  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int RSTATUS_REG        = 30;
  localparam int MULT_EXC           = 1;
  localparam int DIV_EXC            = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/multdiv_step.sv
// One combinational iteration: shift-add for multiply, restoring trial subtract for divide.
// {hi, lo} is the shared working pair: accumulator/multiplier or remainder/quotient.
module multdiv_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] shifted;

  // Remainder stays below the divisor magnitude (<= 2^(WIDTH-1)), so hi's top bit is free to drop.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    shifted = {hi[WIDTH-2:0], lo[WIDTH-1]};
    trial   = {1'b0, shifted} - {1'b0, operand};
    if (div_mode) begin
      if (!trial[WIDTH]) begin
        hi_next = trial[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = shifted;
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply/divide unit feeding the register-file write port.
// Define MULTDIV_RSTATUS_WB_EN to redirect exceptional results to the status register.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_MULT,
  input  logic                  ctrl_DIV,
  input  logic [WIDTH-1:0]      data_operandA,
  input  logic [WIDTH-1:0]      data_operandB,
  input  logic [REG_ADDR_W-1:0] ctrl_destReg,
  output logic                  busy,
  output logic [WIDTH-1:0]      data_result,
  output logic                  data_exception,
  output logic                  data_resultRDY,
  output logic                  wb_writeEnable,
  output logic [REG_ADDR_W-1:0] wb_writeReg,
  output logic [WIDTH-1:0]      wb_writeData
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t state, state_next;
  logic [CW-1:0]         cnt;
  logic [WIDTH-1:0]      hi, lo, opmag, hi_next, lo_next;
  logic                  neg, div_zero, div_ovf;
  logic [REG_ADDR_W-1:0] dest;

  logic                  start_ok, last_iter;
  logic [WIDTH-1:0]      mag_a, mag_b;
  logic [2*WIDTH-1:0]    prod_s;
  logic [WIDTH-1:0]      quot_s, fin_result, fin_data;
  logic                  fin_exc, fin_we;
  logic [REG_ADDR_W-1:0] fin_reg;

  multdiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (state == DIV),
    .hi       (hi),
    .lo       (lo),
    .operand  (opmag),
    .hi_next  (hi_next),
    .lo_next  (lo_next)
  );

  // Start qualification and operand magnitudes (-min maps to 2^(WIDTH-1) unsigned).
  always_comb begin
    start_ok  = (state == IDLE) && (ctrl_MULT ^ ctrl_DIV);
    last_iter = (cnt == CW'(WIDTH));
    mag_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    mag_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     state_next = start_ok ? (ctrl_MULT ? MULT : DIV) : IDLE;
      MULT,
      DIV:      state_next = last_iter ? DONE : state;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (ctrl_reset) state <= IDLE;
    else            state <= state_next;
  end

  // Sign correction, exception detection and writeback selection for the final edge.
  always_comb begin
    prod_s = {hi, lo};
    if (neg) prod_s = -prod_s;
    quot_s = neg ? -lo : lo;
    if (state == MULT) begin
      fin_result = prod_s[WIDTH-1:0];
      fin_exc    = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
    end else if (div_zero) begin
      fin_result = {WIDTH{1'b0}};
      fin_exc    = 1'b1;
    end else if (div_ovf) begin
      fin_result = {1'b1, {(WIDTH-1){1'b0}}};
      fin_exc    = 1'b1;
    end else begin
      fin_result = quot_s;
      fin_exc    = 1'b0;
    end
    fin_we   = !fin_exc && (dest != {REG_ADDR_W{1'b0}});
    fin_reg  = dest;
    fin_data = fin_result;
`ifdef MULTDIV_RSTATUS_WB_EN
    if (fin_exc) begin
      fin_we   = 1'b1;
      fin_reg  = REG_ADDR_W'(RSTATUS_REG);
      fin_data = (state == MULT) ? WIDTH'(MULT_EXC) : WIDTH'(DIV_EXC);
    end else begin
      fin_we   = fin_we;
    end
`endif
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      cnt            <= {CW{1'b0}};
      hi             <= {WIDTH{1'b0}};
      lo             <= {WIDTH{1'b0}};
      opmag          <= {WIDTH{1'b0}};
      neg            <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      dest           <= {REG_ADDR_W{1'b0}};
      busy           <= 1'b0;
      data_result    <= {WIDTH{1'b0}};
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      wb_writeEnable <= 1'b0;
      wb_writeReg    <= {REG_ADDR_W{1'b0}};
      wb_writeData   <= {WIDTH{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            cnt      <= {CW{1'b0}};
            hi       <= {WIDTH{1'b0}};
            lo       <= ctrl_MULT ? mag_b : mag_a;
            opmag    <= ctrl_MULT ? mag_a : mag_b;
            neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == {WIDTH{1'b0}});
            div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                        (data_operandB == {WIDTH{1'b1}});
            dest     <= ctrl_destReg;
            busy     <= 1'b1;
          end
        end
        MULT, DIV: begin
          if (last_iter) begin
            data_result    <= fin_result;
            data_exception <= fin_exc;
            data_resultRDY <= 1'b1;
            wb_writeEnable <= fin_we;
            wb_writeReg    <= fin_reg;
            wb_writeData   <= fin_data;
          end else begin
            hi  <= hi_next;
            lo  <= lo_next;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy           <= 1'b0;
          data_exception <= 1'b0;
          data_resultRDY <= 1'b0;
          wb_writeEnable <= 1'b0;
          wb_writeReg    <= {REG_ADDR_W{1'b0}};
          wb_writeData   <= {WIDTH{1'b0}};
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: cycle-level behavioural model plus directed literal checks.
module tb_multdiv_unit;

`ifdef MULTDIV_RSTATUS_WB_EN
  localparam bit EXC_WB = 1'b1;
`else
  localparam bit EXC_WB = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        ctrl_reset, ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [4:0]  ctrl_destReg;
  logic        busy, data_exception, data_resultRDY, wb_writeEnable;
  logic [31:0] data_result, wb_writeData;
  logic [4:0]  wb_writeReg;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rdy    = 0;

  // model state: what the outputs must be after the most recent edge
  logic        m_valid = 1'b0, m_busy, m_rdy, m_exc, m_we;
  int          m_left;
  logic [31:0] m_res, m_data;
  logic [4:0]  m_reg;
  logic [31:0] p_res, p_data;
  logic        p_exc, p_we;
  logic [4:0]  p_reg;

  multdiv_unit dut (
    .clock          (clock),
    .ctrl_reset     (ctrl_reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_destReg   (ctrl_destReg),
    .busy           (busy),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .wb_writeEnable (wb_writeEnable),
    .wb_writeReg    (wb_writeReg),
    .wb_writeData   (wb_writeData)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, from plain signed arithmetic.
  task automatic predict(input logic mult, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    longint p;
    if (mult) begin
      p     = longint'($signed(a)) * longint'($signed(b));
      p_res = p[31:0];
      p_exc = (p != longint'($signed(p_res)));
    end else if (b == 32'd0) begin
      p_res = 32'd0;
      p_exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      p_res = 32'h8000_0000;
      p_exc = 1'b1;
    end else begin
      p_res = $signed(a) / $signed(b);
      p_exc = 1'b0;
    end
    if (p_exc && EXC_WB) begin
      p_we   = 1'b1;
      p_reg  = 5'd30;
      p_data = mult ? 32'd1 : 32'd2;
    end else begin
      p_we   = !p_exc && (d != 5'd0);
      p_reg  = d;
      p_data = p_res;
    end
  endtask

  task automatic model_edge(input logic rst, input logic mult, input logic div,
                            input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    if (rst) begin
      m_valid = 1'b1; m_busy = 1'b0; m_rdy = 1'b0; m_left = 0;
      m_res = 32'd0; m_exc = 1'b0; m_we = 1'b0; m_reg = 5'd0; m_data = 32'd0;
    end else if (m_rdy) begin
      m_rdy = 1'b0; m_busy = 1'b0; m_exc = 1'b0; m_we = 1'b0; m_reg = 5'd0; m_data = 32'd0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_rdy = 1'b1; m_res = p_res; m_exc = p_exc; m_we = p_we; m_reg = p_reg; m_data = p_data;
      end
    end else if (mult ^ div) begin
      m_busy = 1'b1;
      m_left = 33;
      predict(mult, a, b, d);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare on the falling edge.
  task automatic tick(input logic rst, input logic mult, input logic div,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    ctrl_reset = rst; ctrl_MULT = mult; ctrl_DIV = div;
    data_operandA = a; data_operandB = b; ctrl_destReg = d;
    @(posedge clock);
    model_edge(rst, mult, div, a, b, d);
    @(negedge clock);
    if (m_valid) begin
      chk("busy",  {31'd0, busy}, {31'd0, m_busy});
      chk("rdy",   {31'd0, data_resultRDY}, {31'd0, m_rdy});
      chk("result", data_result, m_res);
      chk("exception", {31'd0, data_exception}, {31'd0, m_exc});
      chk("wb_we", {31'd0, wb_writeEnable}, {31'd0, m_we});
      chk("wb_reg", {27'd0, wb_writeReg}, {27'd0, m_reg});
      chk("wb_data", wb_writeData, m_data);
      if (data_resultRDY === 1'b1) n_rdy++;
    end
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 6))
      0:       rand_op = 32'd0;
      1:       rand_op = 32'hFFFF_FFFF;
      2:       rand_op = 32'h8000_0000;
      3:       rand_op = 32'($urandom_range(0, 40)) - 32'd20;
      4:       rand_op = 32'($urandom_range(0, 65535)) - 32'd32768;
      default: rand_op = $urandom;
    endcase
  endfunction

  task automatic idle_tick();
    tick(1'b0, 1'b0, 1'b0, rand_op(), rand_op(), 5'($urandom_range(0, 31)));
  endtask

  // Waits (bounded) for the strobe after a start and pins latency and values to literals.
  task automatic wait_rdy(input string name, input logic [31:0] exp_res, input logic exp_exc,
                          input logic exp_we, input logic [4:0] exp_reg, input logic [31:0] exp_data);
    int lat = -1;
    for (int i = 1; i <= 40; i++) begin
      idle_tick();
      if (data_resultRDY === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk({name, " latency"}, 32'(lat), 32'd33);
    chk({name, " result"}, data_result, exp_res);
    chk({name, " exc"}, {31'd0, data_exception}, {31'd0, exp_exc});
    chk({name, " we"}, {31'd0, wb_writeEnable}, {31'd0, exp_we});
    chk({name, " reg"}, {27'd0, wb_writeReg}, {27'd0, exp_reg});
    chk({name, " data"}, wb_writeData, exp_data);
  endtask

  task automatic run_op(input string name, input logic mult, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic [31:0] exp_res, input logic exp_exc,
                        input logic exp_we, input logic [4:0] exp_reg, input logic [31:0] exp_data);
    tick(1'b0, mult, !mult, a, b, d);
    wait_rdy(name, exp_res, exp_exc, exp_we, exp_reg, exp_data);
    idle_tick();
  endtask

  initial begin
    tick(1'b1, 1'b1, 1'b0, 32'd5, 32'd5, 5'd9);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset result", data_result, 32'd0);
    chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    idle_tick();

    run_op("mul 7x-6", 1'b1, 32'd7, 32'hFFFF_FFFA, 5'd3, 32'hFFFF_FFD6, 1'b0, 1'b1, 5'd3, 32'hFFFF_FFD6);
    run_op("mul ovf", 1'b1, 32'h0001_0000, 32'h0001_0000, 5'd5, 32'd0, 1'b1,
           EXC_WB, EXC_WB ? 5'd30 : 5'd5, EXC_WB ? 32'd1 : 32'd0);
    run_op("div -17/5", 1'b0, 32'hFFFF_FFEF, 32'd5, 5'd4, 32'hFFFF_FFFD, 1'b0, 1'b1, 5'd4, 32'hFFFF_FFFD);
    run_op("div 9/0", 1'b0, 32'd9, 32'd0, 5'd6, 32'd0, 1'b1,
           EXC_WB, EXC_WB ? 5'd30 : 5'd6, EXC_WB ? 32'd2 : 32'd0);
    run_op("div min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1'b1,
           EXC_WB, EXC_WB ? 5'd30 : 5'd7, EXC_WB ? 32'd2 : 32'h8000_0000);
    run_op("mul r0", 1'b1, 32'd3, 32'd4, 5'd0, 32'd12, 1'b0, 1'b0, 5'd0, 32'd12);

    // Both starts together: no operation.
    tick(1'b0, 1'b1, 1'b1, 32'd2, 32'd2, 5'd1);
    chk("both starts busy", {31'd0, busy}, 32'd0);
    idle_tick();

    // Divide pulse during a multiply, then a start in the DONE cycle, then a real back-to-back start.
    tick(1'b0, 1'b1, 1'b0, 32'd100, 32'hFFFF_FFFD, 5'd8);
    for (int i = 1; i < 10; i++) idle_tick();
    tick(1'b0, 1'b0, 1'b1, 32'd50, 32'd7, 5'd9);
    for (int i = 11; i <= 32; i++) idle_tick();
    idle_tick();
    chk("intrude rdy", {31'd0, data_resultRDY}, 32'd1);
    chk("intrude result", data_result, 32'hFFFF_FED4);
    tick(1'b0, 1'b0, 1'b1, 32'd50, 32'd7, 5'd9);
    chk("done start busy", {31'd0, busy}, 32'd0);
    run_op("b2b div", 1'b0, 32'd50, 32'd7, 5'd9, 32'd7, 1'b0, 1'b1, 5'd9, 32'd7);

    // Reset at iteration 15 aborts silently.
    tick(1'b0, 1'b1, 1'b0, 32'd11, 32'd13, 5'd2);
    for (int i = 1; i < 15; i++) idle_tick();
    tick(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort result", data_result, 32'd0);
    chk("abort we", {31'd0, wb_writeEnable}, 32'd0);
    for (int i = 0; i < 40; i++) idle_tick();
    run_op("after abort", 1'b1, 32'd11, 32'd13, 5'd2, 32'd143, 1'b0, 1'b1, 5'd2, 32'd143);

    // Random traffic: starts, stray starts while busy, double starts, rare resets.
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      tick((r == 99) && ($urandom_range(0, 3) == 0), (r < 8) || (r == 16), (r >= 8) && (r <= 16),
           rand_op(), rand_op(), 5'($urandom_range(0, 31)));
    end
    n_checks++;
    if (n_rdy < 20) begin
      n_fail++;
      $display("FAIL completions actual=%0d required>=20", n_rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
